// File: rtl/sram_store_buffer_pkg.sv
// sram_store_buffer_pkg: SRAM bus field widths, size encodings and packed store entry shared with the bridge
package sram_store_buffer_pkg;
    localparam int SIZE_W = 2;
    localparam int STRB_W = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [SIZE_W-1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef struct packed {
        logic [SIZE_W-1:0] size;
        logic [STRB_W-1:0] wstrb;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);
    localparam int REQ_W   = 1 + ENTRY_W;
    localparam int RSP_W   = 2 + DATA_W;
endpackage

// File: rtl/sram_store_buffer_if.sv
// sram_store_buffer_if: SRAM-like request/response bus, master issues requests, slave answers
interface sram_store_buffer_if;
    import sram_store_buffer_pkg::*;
    logic              req;
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [STRB_W-1:0] wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    modport master (output req, wr, size, wstrb, addr, wdata, input addr_ok, data_ok, rdata);
    modport slave  (input req, wr, size, wstrb, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sram_store_buffer_fifo.sv
// sram_store_buffer_fifo: synchronous store FIFO with head outputs, count and full/empty flags
module sram_store_buffer_fifo
    import sram_store_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  entry_t                       i_din,
    output entry_t                       o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_full,
    output logic                         o_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    entry_t          r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    // Entry storage needs no reset: only slots below count are ever read
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = r_count == CW'(DEPTH);
    assign o_empty = r_count == '0;
endmodule

// File: rtl/sram_store_buffer.sv
// sram_store_buffer: posted-write buffer that acks stores early and lets loads pass only when no store is outstanding
module sram_store_buffer
    import sram_store_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sram_store_buffer_if.slave   cpu,
    sram_store_buffer_if.master  mem
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH + 1) + 1;

    logic [IW-1:0] r_st_inflight;
    logic          r_ld_pend;
    logic          r_ack_q;

    entry_t        w_din;
    entry_t        w_head;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_drain;
    logic          w_ld_try;
    logic          w_st_ret;

    sram_store_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_din),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Gating with rst_n keeps every output low while reset is held, even with a request pending
    assign w_din    = {cpu.size, cpu.wstrb, cpu.addr, cpu.wdata};
    assign w_push   = rst_n & cpu.req & cpu.wr & !w_full & !r_ld_pend;
    assign w_drain  = !w_empty & !r_ld_pend;
    assign w_ld_try = rst_n & cpu.req & !cpu.wr & (w_count == '0) & (r_st_inflight == '0) & !r_ld_pend;
    assign w_pop    = w_drain & mem.addr_ok;
    assign w_st_ret = !r_ld_pend & mem.data_ok;

    // Drain wins the downstream port; a load can only try when the FIFO is empty anyway
    assign mem.req   = w_drain | w_ld_try;
    assign mem.wr    = w_drain;
    assign mem.size  = w_drain ? w_head.size  : cpu.size;
    assign mem.wstrb = w_drain ? w_head.wstrb : cpu.wstrb;
    assign mem.addr  = w_drain ? w_head.addr  : cpu.addr;
    assign mem.wdata = w_drain ? w_head.wdata : cpu.wdata;

    assign cpu.addr_ok = w_push | (w_ld_try & mem.addr_ok);
    assign cpu.data_ok = r_ack_q | (r_ld_pend & mem.data_ok);
    assign cpu.rdata   = mem.rdata;

    // Ordering bookkeeping: store ack delay, pending load, stores awaiting bridge response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack_q       <= 1'b0;
            r_ld_pend     <= 1'b0;
            r_st_inflight <= '0;
        end else begin
            r_ack_q       <= w_push;
            r_ld_pend     <= (w_ld_try & mem.addr_ok) | (r_ld_pend & !mem.data_ok);
            r_st_inflight <= r_st_inflight + IW'(w_pop) - IW'(w_st_ret);
        end
    end
endmodule

// File: tb/tb_sram_store_buffer.sv
// tb_sram_store_buffer: directed checks of store posting, load ordering, wrap and reset
module tb_sram_store_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    sram_store_buffer_if cpu_bus ();
    sram_store_buffer_if mem_bus ();

    sram_store_buffer #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cpu   (cpu_bus.slave),
        .mem   (mem_bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_drive(input logic req, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        cpu_bus.req   = req;
        cpu_bus.wr    = wr;
        cpu_bus.size  = 2'd2;
        cpu_bus.wstrb = 4'hF;
        cpu_bus.addr  = addr;
        cpu_bus.wdata = wdata;
    endtask

    task automatic mem_drive(input logic aok, input logic dok, input logic [31:0] rdata);
        mem_bus.addr_ok = aok;
        mem_bus.data_ok = dok;
        mem_bus.rdata   = rdata;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
        mem_drive(1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_addr_ok", 32'(cpu_bus.addr_ok), 32'd0);
        chk("rst_data_ok", 32'(cpu_bus.data_ok), 32'd0);
        chk("rst_mem_req", 32'(mem_bus.req), 32'd0);
        step();
        rst_n = 1'b1;

        // single store
        cpu_drive(1'b1, 1'b1, 32'h1C00_0000, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("st1_addr_ok", 32'(cpu_bus.addr_ok), 32'd1);
        chk("st1_data_ok_early", 32'(cpu_bus.data_ok), 32'd0);
        chk("st1_mem_req_early", 32'(mem_bus.req), 32'd0);
        step();
        cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
        mem_drive(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("st1_data_ok", 32'(cpu_bus.data_ok), 32'd1);
        chk("st1_mem_req", 32'(mem_bus.req), 32'd1);
        chk("st1_mem_wr", 32'(mem_bus.wr), 32'd1);
        chk("st1_mem_addr", mem_bus.addr, 32'h1C00_0000);
        chk("st1_mem_wdata", mem_bus.wdata, 32'hDEAD_BEEF);
        step();
        mem_drive(1'b0, 1'b1, 32'h0);
        @(negedge clk);
        chk("st1_resp_hidden", 32'(cpu_bus.data_ok), 32'd0);
        chk("st1_mem_idle", 32'(mem_bus.req), 32'd0);
        step();
        do_reset();

        // five back-to-back stores into a stalled bridge
        for (int i = 0; i < 4; i++) begin
            cpu_drive(1'b1, 1'b1, 32'h200 + 32'(4 * i), 32'hA0 + 32'(i));
            @(negedge clk);
            chk($sformatf("bb_accept%0d", i), 32'(cpu_bus.addr_ok), 32'd1);
            step();
        end
        cpu_drive(1'b1, 1'b1, 32'h210, 32'hA4);
        @(negedge clk);
        chk("bb_full_refuse", 32'(cpu_bus.addr_ok), 32'd0);
        chk("bb_ack4", 32'(cpu_bus.data_ok), 32'd1);
        step();
        @(negedge clk);
        chk("bb_full_refuse2", 32'(cpu_bus.addr_ok), 32'd0);
        chk("bb_no_ack", 32'(cpu_bus.data_ok), 32'd0);
        step();
        mem_drive(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("bb_pop_head", mem_bus.addr, 32'h200);
        chk("bb_pop_no_free", 32'(cpu_bus.addr_ok), 32'd0);
        step();
        mem_drive(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("bb_fifth_accept", 32'(cpu_bus.addr_ok), 32'd1);
        step();
        cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
        mem_drive(1'b1, 1'b0, 32'h0);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk($sformatf("bb_drain%0d", j), mem_bus.addr, 32'h204 + 32'(4 * j));
            step();
        end
        @(negedge clk);
        chk("bb_drained", 32'(mem_bus.req), 32'd0);
        step();
        do_reset();

        // store then load of the same address
        cpu_drive(1'b1, 1'b1, 32'h100, 32'h5A5A_1234);
        @(negedge clk);
        chk("ord_st_accept", 32'(cpu_bus.addr_ok), 32'd1);
        step();
        cpu_drive(1'b1, 1'b0, 32'h100, 32'h0);
        mem_drive(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("ord_drain_wr", 32'(mem_bus.wr), 32'd1);
        chk("ord_ld_held_a", 32'(cpu_bus.addr_ok), 32'd0);
        step();
        @(negedge clk);
        chk("ord_ld_held_b", 32'(cpu_bus.addr_ok), 32'd0);
        chk("ord_no_req_inflight", 32'(mem_bus.req), 32'd0);
        step();
        mem_drive(1'b1, 1'b1, 32'h0);
        @(negedge clk);
        chk("ord_ld_held_c", 32'(cpu_bus.addr_ok), 32'd0);
        chk("ord_resp_hidden", 32'(cpu_bus.data_ok), 32'd0);
        step();
        mem_drive(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("ord_ld_req", 32'(mem_bus.req), 32'd1);
        chk("ord_ld_wr", 32'(mem_bus.wr), 32'd0);
        chk("ord_ld_addr", mem_bus.addr, 32'h100);
        chk("ord_ld_accept", 32'(cpu_bus.addr_ok), 32'd1);
        step();
        cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
        mem_drive(1'b0, 1'b1, 32'h5A5A_1234);
        @(negedge clk);
        chk("ord_ld_data_ok", 32'(cpu_bus.data_ok), 32'd1);
        chk("ord_ld_rdata", cpu_bus.rdata, 32'h5A5A_1234);
        step();
        mem_drive(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("ord_ld_done", 32'(cpu_bus.data_ok), 32'd0);
        step();
        do_reset();

        // load with bridge latency 3, stores refused while it is pending
        cpu_drive(1'b1, 1'b0, 32'h300, 32'h0);
        mem_drive(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("lat_ld_accept", 32'(cpu_bus.addr_ok), 32'd1);
        step();
        cpu_drive(1'b1, 1'b1, 32'h400, 32'h1111);
        mem_drive(1'b0, 1'b0, 32'h0);
        for (int k = 1; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("lat_st_refuse%0d", k), 32'(cpu_bus.addr_ok), 32'd0);
            chk($sformatf("lat_wait%0d", k), 32'(cpu_bus.data_ok), 32'd0);
            chk($sformatf("lat_mem_idle%0d", k), 32'(mem_bus.req), 32'd0);
            step();
        end
        mem_drive(1'b0, 1'b1, 32'hCAFE_F00D);
        @(negedge clk);
        chk("lat_data_ok", 32'(cpu_bus.data_ok), 32'd1);
        chk("lat_rdata", cpu_bus.rdata, 32'hCAFE_F00D);
        chk("lat_st_refuse3", 32'(cpu_bus.addr_ok), 32'd0);
        step();
        mem_drive(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("lat_st_accept", 32'(cpu_bus.addr_ok), 32'd1);
        step();
        cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("lat_st_ack", 32'(cpu_bus.data_ok), 32'd1);
        step();
        do_reset();

        // ten stores streaming through, pop and return overlapping, pointers wrapping
        mem_drive(1'b1, 1'b0, 32'h0);
        for (int k = 0; k <= 10; k++) begin
            if (k < 10) cpu_drive(1'b1, 1'b1, 32'h1000 + 32'(16 * k), 32'(k));
            else cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
            mem_bus.data_ok = (k >= 2);
            @(negedge clk);
            if (k < 10) chk($sformatf("wr_accept%0d", k), 32'(cpu_bus.addr_ok), 32'd1);
            if (k == 0) chk("wr_idle0", 32'(mem_bus.req), 32'd0);
            else chk($sformatf("wr_addr%0d", k - 1), mem_bus.addr, 32'h1000 + 32'(16 * (k - 1)));
            step();
        end
        cpu_drive(1'b1, 1'b0, 32'h2000, 32'h0);
        mem_drive(1'b1, 1'b1, 32'h0);
        @(negedge clk);
        chk("wr_ld_blocked", 32'(cpu_bus.addr_ok), 32'd0);
        chk("wr_ld_noreq", 32'(mem_bus.req), 32'd0);
        step();
        mem_drive(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("wr_ld_accept", 32'(cpu_bus.addr_ok), 32'd1);
        chk("wr_ld_addr", mem_bus.addr, 32'h2000);
        step();
        cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
        mem_drive(1'b0, 1'b1, 32'h7777_0001);
        @(negedge clk);
        chk("wr_ld_rdata", cpu_bus.rdata, 32'h7777_0001);
        chk("wr_ld_data_ok", 32'(cpu_bus.data_ok), 32'd1);
        step();
        do_reset();

        // reset with stores buffered and a load waiting
        mem_drive(1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            cpu_drive(1'b1, 1'b1, 32'h600 + 32'(4 * k), 32'h9000 + 32'(k));
            step();
        end
        cpu_drive(1'b1, 1'b0, 32'h500, 32'h0);
        @(negedge clk);
        chk("mr_drain_req", 32'(mem_bus.req), 32'd1);
        chk("mr_ld_held", 32'(cpu_bus.addr_ok), 32'd0);
        step();
        rst_n = 1'b0;
        mem_drive(1'b1, 1'b0, 32'h0);
        #1;
        chk("mr_rst_mem_req", 32'(mem_bus.req), 32'd0);
        chk("mr_rst_addr_ok", 32'(cpu_bus.addr_ok), 32'd0);
        chk("mr_rst_data_ok", 32'(cpu_bus.data_ok), 32'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_fresh_wr", 32'(mem_bus.wr), 32'd0);
        chk("mr_fresh_addr", mem_bus.addr, 32'h500);
        chk("mr_fresh_accept", 32'(cpu_bus.addr_ok), 32'd1);
        step();
        cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
        mem_drive(1'b0, 1'b1, 32'h0BAD_F00D);
        @(negedge clk);
        chk("mr_fresh_data", cpu_bus.rdata, 32'h0BAD_F00D);
        chk("mr_fresh_data_ok", 32'(cpu_bus.data_ok), 32'd1);
        step();
        mem_drive(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("mr_no_stale", 32'(mem_bus.req), 32'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
